// File: rtl/dtmf_digit_collector.sv
// rtl/dtmf_digit_collector.sv - debounces per-frame DTMF tone codes into single digit events queued in a FWFT FIFO
//
// Purpose:
//   Sits after the tone detector. Each tone_valid strobe delivers one frame
//   result. A code must repeat ON_FRAMES times in a row to be accepted.
//   It is released after OFF_FRAMES consecutive frames that do not match it.
//   Each accepted key is pushed once into a first-word-fall-through FIFO,
//   and the consumer drains that FIFO with a valid/ready handshake.
//
// Ports:
//   clock, reset_n            rising-edge clock; synchronous active-low reset
//   tone_valid, tone_code     per-frame detector result (code 0 = no tone)
//   digit_valid, digit_ready  FIFO head handshake
//   digit_code                FIFO head; holds its last value while empty
//   fifo_count                entries held, 0..FIFO_DEPTH
//   overflow, overflow_clr    sticky drop flag and its clear
//   locked                    a key is currently held

module dtmf_digit_collector #(
    parameter int TONE_W     = 16,
    parameter int ON_FRAMES  = 3,
    parameter int OFF_FRAMES = 2,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tone_valid,
    input  logic [TONE_W-1:0] tone_code,
    output logic              digit_valid,
    input  logic              digit_ready,
    output logic [TONE_W-1:0] digit_code,
    output logic [AW:0]       fifo_count,
    output logic              overflow,
    input  logic              overflow_clr,
    output logic              locked
);

    localparam logic [3:0]  ON_N  = 4'(ON_FRAMES);
    localparam logic [3:0]  OFF_N = 4'(OFF_FRAMES);
    localparam logic [AW:0] FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [TONE_W-1:0] cand, cand_next;
    logic [3:0]        on_cnt, on_cnt_next;
    logic [3:0]        off_cnt, off_cnt_next;
    logic              push;

    // Debounce FSM: state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            cand    <= '0;
            on_cnt  <= '0;
            off_cnt <= '0;
        end else begin
            state   <= state_next;
            cand    <= cand_next;
            on_cnt  <= on_cnt_next;
            off_cnt <= off_cnt_next;
        end
    end

    // Debounce FSM: next state; push is asserted on the accepting frame only
    always_comb begin
        state_next   = state;
        cand_next    = cand;
        on_cnt_next  = on_cnt;
        off_cnt_next = off_cnt;
        push         = 1'b0;
        if (tone_valid) begin
            case (state)
                IDLE: begin
                    if (tone_code != '0) begin
                        state_next  = CANDIDATE;
                        cand_next   = tone_code;
                        on_cnt_next = 4'd1;
                    end
                end
                CANDIDATE: begin
                    if (tone_code == cand) begin
                        on_cnt_next = on_cnt + 4'd1;
                        if (on_cnt + 4'd1 == ON_N) begin
                            push         = 1'b1;
                            off_cnt_next = '0;
                            state_next   = LOCKED;
                        end
                    end else if (tone_code != '0) begin
                        cand_next   = tone_code;
                        on_cnt_next = 4'd1;
                    end else begin
                        state_next  = IDLE;
                        on_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    if (tone_code == cand) begin
                        off_cnt_next = '0;
                    end else if (off_cnt + 4'd1 == OFF_N) begin
                        // The releasing frame is deliberately not reused as a candidate
                        state_next   = IDLE;
                        off_cnt_next = '0;
                        on_cnt_next  = '0;
                    end else begin
                        off_cnt_next = off_cnt + 4'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Digit FIFO
    logic [TONE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr, rd_next;
    logic [AW:0]       count, count_next;
    logic [TONE_W-1:0] head_next;
    logic              do_pop, do_push, drop;

    always_comb begin
        do_pop  = (count != '0) && digit_ready;
        do_push = push && ((count != FULL) || do_pop);
        drop    = push && (count == FULL) && !do_pop;
        rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - (AW + 1)'(1);
        end
        // The head is registered so it can hold its last value once drained.
        // If everything older leaves this edge, the new head is the pushed word.
        head_next = digit_code;
        if (do_push && (count == (AW + 1)'(do_pop))) begin
            head_next = cand;
        end else if (count_next != '0) begin
            head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= cand;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            digit_code <= '0;
            overflow   <= 1'b0;
        end else begin
            rd_ptr     <= rd_next;
            wr_ptr     <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            count      <= count_next;
            digit_code <= head_next;
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign digit_valid = (count != '0);
    assign fifo_count  = count;
    assign locked      = (state == LOCKED);

endmodule

// File: tb/tb_dtmf_digit_collector.sv
// tb/tb_dtmf_digit_collector.sv - self-checking bench for dtmf_digit_collector

module tb_dtmf_digit_collector;

    localparam int ON    = 3;
    localparam int OFF   = 2;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        tone_valid = 1'b0;
    logic [15:0] tone_code = '0;
    logic        digit_valid;
    logic        digit_ready = 1'b0;
    logic [15:0] digit_code;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    logic        locked;

    int n_checks = 0;
    int n_fails  = 0;

    dtmf_digit_collector #(
        .TONE_W(16), .ON_FRAMES(ON), .OFF_FRAMES(OFF), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .tone_valid(tone_valid), .tone_code(tone_code),
        .digit_valid(digit_valid), .digit_ready(digit_ready),
        .digit_code(digit_code), .fifo_count(fifo_count),
        .overflow(overflow), .overflow_clr(overflow_clr),
        .locked(locked)
    );

    always #5 clock = ~clock;

    // Reference model: run-length view of the frame stream plus a queue
    logic [15:0] mq[$];
    logic [15:0] m_last = '0;
    bit          m_ovf = 1'b0;
    bit          m_locked = 1'b0;
    logic [15:0] m_key = '0;
    int          m_miss = 0;
    logic [15:0] m_run_code = '0;
    int          m_run_len = 0;

    task automatic model_update();
        bit          emit;
        bit          pop;
        bit          drop;
        logic [15:0] ev;
        emit = 1'b0;
        ev   = '0;
        if (!reset_n) begin
            mq.delete();
            m_last = '0; m_ovf = 1'b0; m_locked = 1'b0; m_key = '0;
            m_miss = 0; m_run_code = '0; m_run_len = 0;
            return;
        end
        if (tone_valid) begin
            if (!m_locked) begin
                if (tone_code == 16'h0) m_run_len = 0;
                else if (m_run_len > 0 && tone_code == m_run_code) m_run_len++;
                else begin m_run_code = tone_code; m_run_len = 1; end
                if (m_run_len == ON) begin
                    emit = 1'b1; ev = m_run_code;
                    m_locked = 1'b1; m_key = m_run_code; m_miss = 0;
                end
            end else begin
                if (tone_code == m_key) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss == OFF) begin m_locked = 1'b0; m_run_len = 0; end
                end
            end
        end
        pop  = (mq.size() > 0) && digit_ready;
        drop = emit && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (emit && !drop) mq.push_back(ev);
        if (drop) m_ovf = 1'b1;
        else if (overflow_clr) m_ovf = 1'b0;
        if (mq.size() > 0) m_last = mq[0];
    endtask

    task automatic step(input logic tv, input logic [15:0] code, input logic rdy, input logic clr);
        tone_valid = tv; tone_code = code; digit_ready = rdy; overflow_clr = clr;
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(1'b1, 16'h0031, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        n_checks++;
        if ({digit_valid, digit_code, fifo_count, overflow, locked} !== 23'h0) begin
            n_fails++;
            $display("FAIL reset_outputs: got v=%0b code=%h cnt=%0d ovf=%0b lk=%0b want all 0",
                     digit_valid, digit_code, fifo_count, overflow, locked);
        end
        reset_n = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_single_digit();
        step(1'b1, 16'h0031, 1'b0, 1'b0);
        step(1'b1, 16'h0031, 1'b0, 1'b0);
        n_checks++;
        if (digit_valid !== 1'b0 || locked !== 1'b0) begin
            n_fails++; $display("FAIL single_frame2: got v=%0b lk=%0b want 0 0", digit_valid, locked);
        end
        step(1'b1, 16'h0031, 1'b0, 1'b0);
        n_checks++;
        if (digit_valid !== 1'b1 || digit_code !== 16'h0031 || fifo_count !== 4'd1 || locked !== 1'b1) begin
            n_fails++;
            $display("FAIL single_frame3: got v=%0b code=%h cnt=%0d lk=%0b want 1 0031 1 1",
                     digit_valid, digit_code, fifo_count, locked);
        end
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (locked !== 1'b1) begin n_fails++; $display("FAIL single_zero1_locked: got %0b want 1", locked); end
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (locked !== 1'b0 || fifo_count !== 4'd1) begin
            n_fails++; $display("FAIL single_release: got lk=%0b cnt=%0d want 0 1", locked, fifo_count);
        end
        step(1'b0, 16'h0, 1'b1, 1'b0);
        n_checks++;
        if (digit_valid !== 1'b0 || digit_code !== 16'h0031) begin
            n_fails++; $display("FAIL single_drain: got v=%0b code=%h want 0 0031", digit_valid, digit_code);
        end
    endtask

    task automatic test_restart();
        logic [15:0] seq [5];
        seq = '{16'h0031, 16'h0031, 16'h0042, 16'h0042, 16'h0042};
        for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0, 1'b0);
        n_checks++;
        if (digit_valid !== 1'b0) begin n_fails++; $display("FAIL restart_no_0031: got v=%0b want 0", digit_valid); end
        step(1'b1, seq[4], 1'b0, 1'b0);
        n_checks++;
        if (digit_valid !== 1'b1 || digit_code !== 16'h0042 || fifo_count !== 4'd1) begin
            n_fails++;
            $display("FAIL restart_digit: got v=%0b code=%h cnt=%0d want 1 0042 1", digit_valid, digit_code, fifo_count);
        end
        step(1'b1, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h0, 1'b1, 1'b0);
        n_checks++;
        if (fifo_count !== 4'd0 || locked !== 1'b0) begin
            n_fails++; $display("FAIL restart_cleanup: got cnt=%0d lk=%0b want 0 0", fifo_count, locked);
        end
    endtask

    task automatic test_glitch();
        logic [15:0] seq [3];
        seq = '{16'h0000, 16'h0031, 16'h0031};
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0031, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq[i], 1'b0, 1'b0);
            n_checks++;
            if (locked !== 1'b1 || fifo_count !== 4'd1) begin
                n_fails++; $display("FAIL glitch_hold%0d: got lk=%0b cnt=%0d want 1 1", i, locked, fifo_count);
            end
        end
        step(1'b1, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h0, 1'b0, 1'b0);
        n_checks++;
        if (locked !== 1'b0 || fifo_count !== 4'd1) begin
            n_fails++; $display("FAIL glitch_release: got lk=%0b cnt=%0d want 0 1", locked, fifo_count);
        end
        step(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic key(input logic [15:0] code, input logic rdy_on_accept);
        step(1'b1, code, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, code, 1'b0, 1'b0);
        step(1'b1, code, rdy_on_accept, 1'b0);
        step(1'b1, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) key(16'h0100 + 16'(i), 1'b0);
        n_checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
            n_fails++; $display("FAIL ovf_full: got cnt=%0d ovf=%0b want 8 1", fifo_count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (digit_valid !== 1'b1 || digit_code !== 16'h0100 + 16'(i)) begin
                n_fails++; $display("FAIL ovf_drain%0d: got v=%0b code=%h want 1 %h", i, digit_valid, digit_code, 16'h0100 + 16'(i));
            end
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        n_checks++;
        if (digit_valid !== 1'b0 || digit_code !== 16'h0107 || overflow !== 1'b1) begin
            n_fails++; $display("FAIL ovf_empty: got v=%0b code=%h ovf=%0b want 0 0107 1", digit_valid, digit_code, overflow);
        end
        step(1'b0, 16'h0, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0) begin n_fails++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
        step(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) key(16'h0200 + 16'(i), 1'b0);
        key(16'h02FF, 1'b1);
        n_checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
            n_fails++; $display("FAIL fpp_count: got cnt=%0d ovf=%0b want 8 0", fifo_count, overflow);
        end
        for (int i = 1; i < 9; i++) begin
            n_checks++;
            if (digit_code !== ((i == 8) ? 16'h02FF : 16'h0200 + 16'(i))) begin
                n_fails++; $display("FAIL fpp_order%0d: got %h want %h", i, digit_code, (i == 8) ? 16'h02FF : 16'h0200 + 16'(i));
            end
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        n_checks++;
        if (fifo_count !== 4'd0) begin n_fails++; $display("FAIL fpp_empty: got cnt=%0d want 0", fifo_count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) key(16'h0300 + 16'(i), 1'b0);
        step(1'b1, 16'h03AA, 1'b0, 1'b0);
        step(1'b1, 16'h03AA, 1'b0, 1'b0);
        reset_n = 1'b0;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        n_checks++;
        if ({digit_valid, digit_code, fifo_count, overflow, locked} !== 23'h0) begin
            n_fails++;
            $display("FAIL midreset_outputs: got v=%0b code=%h cnt=%0d ovf=%0b lk=%0b want all 0",
                     digit_valid, digit_code, fifo_count, overflow, locked);
        end
        step(1'b1, 16'h03AA, 1'b0, 1'b0);
        step(1'b1, 16'h03AA, 1'b0, 1'b0);
        n_checks++;
        if (digit_valid !== 1'b0) begin n_fails++; $display("FAIL midreset_restart: got v=%0b want 0", digit_valid); end
        step(1'b1, 16'h03AA, 1'b0, 1'b0);
        n_checks++;
        if (digit_valid !== 1'b1 || digit_code !== 16'h03AA) begin
            n_fails++; $display("FAIL midreset_third: got v=%0b code=%h want 1 03AA", digit_valid, digit_code);
        end
        step(1'b1, 16'h0, 1'b1, 1'b0);
        step(1'b1, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] alpha [4];
        logic [15:0] code;
        alpha = '{16'h0000, 16'h0031, 16'h0042, 16'h0055};
        code = '0;
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 99) < 30) code = alpha[$urandom_range(0, 3)];
            step(($urandom_range(0, 3) != 0), code, ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 5));
            n_checks++;
            if (digit_valid !== (mq.size() != 0) || fifo_count !== 4'(mq.size()) ||
                digit_code !== m_last || overflow !== m_ovf || locked !== m_locked) begin
                n_fails++;
                $display("FAIL random_c%0d: got v=%0b cnt=%0d code=%h ovf=%0b lk=%0b want %0b %0d %h %0b %0b",
                         c, digit_valid, fifo_count, digit_code, overflow, locked,
                         mq.size() != 0, mq.size(), m_last, m_ovf, m_locked);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_restart();
        test_glitch();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
